data_memory_v2: RTL and testbench

Parametrised successor to the single-cycle 8-bit data RAM. It is a synchronous single-port data memory with configurable word width and depth. It adds a registered read path with a valid strobe, write-first collision handling, out-of-range address detection, and a post-reset hardware clear sequencer. It sits between the datapath's load/store stage and the rest of the CPU, and presents the same MemRead/MemWrite/DataAddress/DataMemIn/DataMemOut interface plus handshake status.

---
 rtl/data_memory_v2.sv | 71 +++++++
 tb/tb_data_memory_v2.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_v2.sv
// data_memory_v2: single-port data RAM with registered read, write-first collisions,
// out-of-range detection and a post-reset clear sequencer.
module data_memory_v2 #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 256,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              CLK,
    input  logic              ResetN,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAddress,
    input  logic [DATA_W-1:0] DataMemIn,
    output logic [DATA_W-1:0] DataMemOut,
    output logic              ReadValid,
    output logic              AddrError,
    output logic              Ready
);
    typedef enum logic {CLEAR, IDLE} stateType;

    // one extra bit so DEPTH = 2**ADDR_W is representable
    localparam logic [ADDR_W:0] depthLim = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] lastIdx  = (ADDR_W+1)'(DEPTH - 1);

    stateType          state;
    logic [ADDR_W:0]   clearCount;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              clearing;
    logic              inRange;
    logic              doRead;
    logic              doWrite;
    logic              memWe;
    logic [ADDR_W-1:0] wrIndex;
    logic [DATA_W-1:0] wrData;

    assign clearing = state == CLEAR;
    assign inRange  = {1'b0, DataAddress} < depthLim;
    assign doRead   = !clearing && MemRead && inRange;
    assign doWrite  = !clearing && MemWrite && inRange;
    assign memWe    = clearing || doWrite;
    assign wrIndex  = clearing ? clearCount[ADDR_W-1:0] : DataAddress;
    assign wrData   = clearing ? '0 : DataMemIn;

    always_ff @(posedge CLK)
        if (ResetN && memWe) mem[wrIndex] <= wrData;

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state      <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clearCount <= '0;
            DataMemOut <= '0;
            ReadValid  <= 1'b0;
            AddrError  <= 1'b0;
            Ready      <= !CLEAR_ON_RESET;
        end else begin
            ReadValid <= doRead;
            AddrError <= !clearing && (MemRead || MemWrite) && !inRange;
            // a read paired with a write returns the incoming data
            if (doRead) DataMemOut <= MemWrite ? DataMemIn : mem[DataAddress];
            if (clearing) begin
                clearCount <= clearCount + 1'b1;
                if (clearCount == lastIdx) begin
                    state <= IDLE;
                    Ready <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_memory_v2.sv
// tb_data_memory_v2: four parametrisations driven from one stimulus stream and
// checked every cycle against a word-level reference model.
module tb_data_memory_v2;
    logic        CLK = 1'b0;
    logic        ResetN = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] din = '0;

    logic [7:0]  oA, oB, oD;
    logic [15:0] oC;
    logic        rvA, rvB, rvC, rvD, aeA, aeB, aeC, aeD, rdyA, rdyB, rdyC, rdyD;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    data_memory_v2 dutA (.CLK(CLK), .ResetN(ResetN), .MemRead(rd), .MemWrite(wr),
        .DataAddress(addr), .DataMemIn(din[7:0]), .DataMemOut(oA), .ReadValid(rvA),
        .AddrError(aeA), .Ready(rdyA));
    data_memory_v2 #(.DEPTH(200)) dutB (.CLK(CLK), .ResetN(ResetN), .MemRead(rd),
        .MemWrite(wr), .DataAddress(addr), .DataMemIn(din[7:0]), .DataMemOut(oB),
        .ReadValid(rvB), .AddrError(aeB), .Ready(rdyB));
    data_memory_v2 #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dutC (.CLK(CLK), .ResetN(ResetN),
        .MemRead(rd), .MemWrite(wr), .DataAddress(addr[3:0]), .DataMemIn(din),
        .DataMemOut(oC), .ReadValid(rvC), .AddrError(aeC), .Ready(rdyC));
    data_memory_v2 #(.CLEAR_ON_RESET(1'b0)) dutD (.CLK(CLK), .ResetN(ResetN), .MemRead(rd),
        .MemWrite(wr), .DataAddress(addr), .DataMemIn(din[7:0]), .DataMemOut(oD),
        .ReadValid(rvD), .AddrError(aeD), .Ready(rdyD));

    logic [15:0] obsOut [4];
    logic        obsRv [4];
    logic        obsAe [4];
    logic        obsRdy [4];
    assign obsOut[0] = {8'h00, oA};
    assign obsOut[1] = {8'h00, oB};
    assign obsOut[2] = oC;
    assign obsOut[3] = {8'h00, oD};
    assign obsRv[0] = rvA;
    assign obsRv[1] = rvB;
    assign obsRv[2] = rvC;
    assign obsRv[3] = rvD;
    assign obsAe[0] = aeA;
    assign obsAe[1] = aeB;
    assign obsAe[2] = aeC;
    assign obsAe[3] = aeD;
    assign obsRdy[0] = rdyA;
    assign obsRdy[1] = rdyB;
    assign obsRdy[2] = rdyC;
    assign obsRdy[3] = rdyD;

    // reference model: per-instance word store plus a remaining-clear budget
    int          depthOf [4] = '{256, 200, 16, 256};
    bit          clearOf [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int          amask [4] = '{255, 255, 15, 255};
    logic [15:0] dmask [4] = '{16'h00ff, 16'h00ff, 16'hffff, 16'h00ff};
    logic [15:0] mm [4][256];
    bit          kn [4][256];
    int          busy [4];
    logic [15:0] eOut [4];
    bit          eOutKn [4];
    bit          eRv [4];
    bit          eAe [4];
    bit          eRdy [4];

    function automatic void modelReset();
        for (int d = 0; d < 4; d++) begin
            busy[d] = clearOf[d] ? depthOf[d] : 0;
            eOut[d] = '0;
            eOutKn[d] = 1'b1;
            eRv[d] = 1'b0;
            eAe[d] = 1'b0;
            eRdy[d] = !clearOf[d];
            if (clearOf[d])
                for (int i = 0; i < 256; i++) begin
                    mm[d][i] = '0;
                    kn[d][i] = 1'b1;
                end
        end
    endfunction

    function automatic void modelEdge();
        int a;
        bit inr;
        logic [15:0] dv;
        if (!ResetN) begin
            modelReset();
            return;
        end
        for (int d = 0; d < 4; d++) begin
            a = int'(addr) & amask[d];
            dv = din & dmask[d];
            if (busy[d] > 0) begin
                busy[d]--;
                eRv[d] = 1'b0;
                eAe[d] = 1'b0;
                eRdy[d] = busy[d] == 0;
            end else begin
                eRdy[d] = 1'b1;
                inr = a < depthOf[d];
                eAe[d] = (rd || wr) && !inr;
                eRv[d] = rd && inr;
                if (eRv[d]) begin
                    eOut[d] = wr ? dv : mm[d][a];
                    eOutKn[d] = wr || kn[d][a];
                end
                if (wr && inr) begin
                    mm[d][a] = dv;
                    kn[d][a] = 1'b1;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkAll();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("ready%0d", d), 16'(obsRdy[d]), 16'(eRdy[d]));
            chk($sformatf("readValid%0d", d), 16'(obsRv[d]), 16'(eRv[d]));
            chk($sformatf("addrError%0d", d), 16'(obsAe[d]), 16'(eAe[d]));
            if (eOutKn[d]) chk($sformatf("dataOut%0d", d), obsOut[d], eOut[d]);
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [7:0] a, input logic [15:0] dd);
        rd = r;
        wr = w;
        addr = a;
        din = dd;
        @(posedge CLK);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic randCyc();
        logic [7:0] a;
        a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        cyc(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, a, 16'($urandom));
    endtask

    task automatic asyncReset(input int n);
        #2;
        ResetN = 1'b0;
        #1;
        modelReset();
        checkAll();
        repeat (n) begin
            @(posedge CLK);
            modelEdge();
            #1;
            checkAll();
        end
        ResetN = 1'b1;
    endtask

    task automatic clearToReady();
        int n;
        n = 0;
        do begin
            randCyc();
            n++;
        end while (!rdyA && n < 400);
        chk("clearLength", 16'(n), 16'd256);
    endtask

    initial begin
        modelReset();
        repeat (10) begin
            @(posedge CLK);
            modelEdge();
            #1;
            checkAll();
        end
        ResetN = 1'b1;
        cyc(1'b0, 1'b1, 8'd5, 16'h00ff);
        repeat (49) randCyc();
        asyncReset(2);
        clearToReady();

        cyc(1'b1, 1'b0, 8'd0, 16'h0);
        chk("rd0", {7'd0, rvA, oA}, {7'd0, 1'b1, 8'h00});
        cyc(1'b1, 1'b0, 8'd1, 16'h0);
        cyc(1'b1, 1'b0, 8'd255, 16'h0);
        chk("rd255", {7'd0, rvA, oA}, {7'd0, 1'b1, 8'h00});
        chk("rd255B", {14'd0, aeB, rvB}, 16'h0002);
        cyc(1'b1, 1'b0, 8'd5, 16'h0);
        chk("clearIgnoresWrite", {8'd0, oA}, 16'h0000);
        cyc(1'b0, 1'b1, 8'd1, 16'h0003);
        cyc(1'b1, 1'b0, 8'd1, 16'h0);
        chk("wrThenRd", {7'd0, rvA, oA}, {7'd0, 1'b1, 8'h03});
        cyc(1'b0, 1'b0, 8'd0, 16'h0);
        chk("holdNoPulse", {7'd0, rvA, oA}, {7'd0, 1'b0, 8'h03});
        cyc(1'b1, 1'b0, 8'd0, 16'h0);
        chk("rdZero", {8'd0, oA}, 16'h0000);
        cyc(1'b1, 1'b1, 8'h10, 16'h00a5);
        chk("collision", {7'd0, rvA, oA}, {7'd0, 1'b1, 8'ha5});
        cyc(1'b1, 1'b0, 8'h10, 16'h0);
        chk("collisionStored", {8'd0, oA}, 16'h00a5);
        cyc(1'b0, 1'b1, 8'd199, 16'h0042);
        cyc(1'b1, 1'b0, 8'd199, 16'h0);
        cyc(1'b0, 1'b1, 8'd200, 16'h0077);
        chk("oorWrite", {6'd0, aeB, rvB, oB}, {6'd0, 1'b1, 1'b0, 8'h42});
        cyc(1'b1, 1'b0, 8'd199, 16'h0);
        chk("oorNeighbour", {6'd0, aeB, rvB, oB}, {6'd0, 1'b0, 1'b1, 8'h42});

        repeat (800) randCyc();
        asyncReset(1);
        clearToReady();
        repeat (100) randCyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
